// File: rtl/fetch_sequencer.sv
// Fetch/decode sequencer: fetches over a req/ack port, classifies the opcode and issues one
// PC control strobe per instruction. Define FETCH_TIMEOUT_EN to enable the fetch watchdog.
module fetch_sequencer #(
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned INSTR_W     = 19,
    parameter int unsigned STACK_DEPTH = 16
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               zero_flag,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               exec_done,
    output logic               update,
    output logic               branch,
    output logic               call,
    output logic               ret,
    output logic               jump,
    output logic [ADDR_W-1:0]  jump_address,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               halted,
    output logic               stack_fault,
    output logic               bus_fault
);

    localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);

    localparam logic [4:0] OpJmp  = 5'h10;
    localparam logic [4:0] OpBeq  = 5'h11;
    localparam logic [4:0] OpBne  = 5'h12;
    localparam logic [4:0] OpCall = 5'h13;
    localparam logic [4:0] OpRet  = 5'h14;
    localparam logic [4:0] OpHalt = 5'h1F;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExecWait, StCommit, StHalted, StFault
    } state_e;

    state_e              state_q;
    logic                imem_req_q;
    logic [INSTR_W-1:0]  instr_q;
    logic [ADDR_W-1:0]   pc_next_q;
    logic                instr_valid_q;
    logic                update_q, branch_q, call_q, ret_q, jump_q;
    logic                halted_q, stack_fault_q;
    logic [DepthW-1:0]   depth_q;
    logic [4:0]          opcode;
    logic                fetch_timeout;

    assign opcode = instr_q[INSTR_W-1 -: 5];

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_q;
    logic            bus_fault_q;

    // Counter is held at zero outside FETCH, so it restarts on every FETCH entry.
    assign fetch_timeout = (state_q == StFetch) && !imem_ack &&
                           (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q       <= '0;
            bus_fault_q <= 1'b0;
        end else begin
            tmo_q       <= (state_q == StFetch && !imem_ack) ? tmo_q + TmoW'(1) : '0;
            bus_fault_q <= bus_fault_q | fetch_timeout;
        end
    end

    assign bus_fault = bus_fault_q;
`else
    assign fetch_timeout = 1'b0;
    assign bus_fault     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            imem_req_q    <= 1'b0;
            instr_q       <= '0;
            pc_next_q     <= '0;
            instr_valid_q <= 1'b0;
            update_q      <= 1'b0;
            branch_q      <= 1'b0;
            call_q        <= 1'b0;
            ret_q         <= 1'b0;
            jump_q        <= 1'b0;
            halted_q      <= 1'b0;
            stack_fault_q <= 1'b0;
            depth_q       <= '0;
        end else begin
            // Strobes are only ever set for the single COMMIT cycle.
            update_q <= 1'b0;
            branch_q <= 1'b0;
            call_q   <= 1'b0;
            ret_q    <= 1'b0;
            jump_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (run) begin
                        imem_req_q <= 1'b1;
                        state_q    <= StFetch;
                    end
                end
                StFetch: begin
                    if (imem_ack) begin
                        instr_q    <= imem_data;
                        pc_next_q  <= pc_in + ADDR_W'(1);
                        imem_req_q <= 1'b0;
                        state_q    <= StDecode;
                    end else if (fetch_timeout) begin
                        imem_req_q <= 1'b0;
                        state_q    <= StFault;
                    end
                end
                StDecode: begin
                    case (opcode)
                        OpJmp: begin
                            jump_q  <= 1'b1;
                            state_q <= StCommit;
                        end
                        OpBeq, OpBne: begin
                            if ((opcode == OpBeq) == zero_flag) begin
                                branch_q <= 1'b1;
                            end else begin
                                update_q <= 1'b1;
                            end
                            state_q <= StCommit;
                        end
                        OpCall: begin
                            if (depth_q == DepthW'(STACK_DEPTH)) begin
                                stack_fault_q <= 1'b1;
                                state_q       <= StFault;
                            end else begin
                                call_q  <= 1'b1;
                                state_q <= StCommit;
                            end
                        end
                        OpRet: begin
                            if (depth_q == '0) begin
                                stack_fault_q <= 1'b1;
                                state_q       <= StFault;
                            end else begin
                                ret_q   <= 1'b1;
                                state_q <= StCommit;
                            end
                        end
                        OpHalt: begin
                            halted_q <= 1'b1;
                            state_q  <= StHalted;
                        end
                        default: begin
                            instr_valid_q <= 1'b1;
                            state_q       <= StExecWait;
                        end
                    endcase
                end
                StExecWait: begin
                    if (exec_done) begin
                        instr_valid_q <= 1'b0;
                        update_q      <= 1'b1;
                        state_q       <= StCommit;
                    end
                end
                StCommit: begin
                    if (call_q) begin
                        depth_q <= depth_q + DepthW'(1);
                    end else if (ret_q) begin
                        depth_q <= depth_q - DepthW'(1);
                    end
                    if (run) begin
                        imem_req_q <= 1'b1;
                        state_q    <= StFetch;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StHalted, StFault: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign imem_req     = imem_req_q;
    // PC only moves at the end of COMMIT, so pc_in is stable for the whole fetch.
    assign imem_addr    = imem_req_q ? pc_in : '0;
    assign instr_out    = instr_q;
    assign instr_valid  = instr_valid_q;
    assign update       = update_q;
    assign branch       = branch_q;
    assign call         = call_q;
    assign ret          = ret_q;
    assign jump         = jump_q;
    assign jump_address = ADDR_W'(instr_q[13:0]);
    assign pc_next      = pc_next_q;
    assign halted       = halted_q;
    assign stack_fault  = stack_fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer with hand-written fault/halt/reset sequences.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, imem_ack, zero_flag, exec_done;
    logic [18:0] pc_in, imem_data;
    logic        imem_req, instr_valid, update, branch, call, ret, jump;
    logic        halted, stack_fault, bus_fault;
    logic [18:0] imem_addr, instr_out, jump_address, pc_next;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .STACK_DEPTH(16)
`ifdef FETCH_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk(clk), .reset(reset), .run(run), .pc_in(pc_in),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .zero_flag(zero_flag), .instr_out(instr_out),
        .instr_valid(instr_valid), .exec_done(exec_done), .update(update),
        .branch(branch), .call(call), .ret(ret), .jump(jump),
        .jump_address(jump_address), .pc_next(pc_next), .halted(halted),
        .stack_fault(stack_fault), .bus_fault(bus_fault)
    );

    // code: 0 none, 1 update, 2 branch, 3 call, 4 ret, 5 jump
    typedef struct {
        logic [18:0] pc;
        logic [18:0] instr;
        logic        zero;
        int          ackw;
        int          ew;
        int          code;
        logic [18:0] pn;
        int          vcyc;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [18:0] pc, input logic [18:0] instr,
                         input int ackw);
        int n = 0;
        while (!imem_req && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, imem_req, 1);
        pc_in = pc;
        #1;
        check({tag, "_addr"}, imem_addr, pc);
        for (int k = 0; k < ackw; k++) begin
            @(negedge clk);
            check({tag, "_hold"}, {imem_req, imem_addr}, {1'b1, pc});
        end
        imem_ack = 1'b1;
        imem_data = instr;
        @(negedge clk);
        imem_ack = 1'b0;
        check({tag, "_req_drop"}, imem_req, 0);
    endtask

    task automatic collect(input int ew, output int code, output int ncyc, output int vcyc,
                           output int lat, output logic [18:0] ja, output logic [18:0] pn,
                           output int excl);
        logic [4:0] s;
        code = 0; ncyc = 0; vcyc = 0; lat = -1; ja = '0; pn = '0; excl = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            s = {update, branch, call, ret, jump};
            if ($countones(s) > 1) excl++;
            if (s != 5'b0) begin
                if (ncyc == 0) lat = c;
                ncyc++;
                code = update ? 1 : branch ? 2 : call ? 3 : ret ? 4 : 5;
                ja = jump_address;
                pn = pc_next;
            end else if (ncyc > 0) begin
                break;
            end
            if (instr_valid) begin
                vcyc++;
                exec_done = (vcyc >= ew);
            end else begin
                exec_done = 1'b0;
            end
        end
        exec_done = 1'b0;
    endtask

    initial begin
        int code, ncyc, vcyc, lat, excl, ok, nreq;
        logic [18:0] ja, pn;

        vecs[0] = '{19'h00005, 19'h00123, 1'b0, 2, 3, 1, 19'h00006, 3};
        vecs[1] = '{19'h00010, {5'h10, 14'h0ABC}, 1'b0, 0, 1, 5, 19'h00011, 0};
        vecs[2] = '{19'h00020, {5'h11, 14'h0100}, 1'b1, 0, 1, 2, 19'h00021, 0};
        vecs[3] = '{19'h7FFFF, {5'h11, 14'h0101}, 1'b0, 1, 1, 1, 19'h00000, 0};
        vecs[4] = '{19'h00030, {5'h12, 14'h0200}, 1'b0, 0, 1, 2, 19'h00031, 0};
        vecs[5] = '{19'h00031, {5'h12, 14'h0201}, 1'b1, 0, 1, 1, 19'h00032, 0};
        vecs[6] = '{19'h00040, {5'h13, 14'h1234}, 1'b0, 1, 1, 3, 19'h00041, 0};
        vecs[7] = '{19'h01234, {5'h14, 14'h0000}, 1'b0, 0, 1, 4, 19'h01235, 0};
        vecs[8] = '{19'h00041, {5'h15, 14'h3FFF}, 1'b0, 0, 1, 1, 19'h00042, 1};
        vecs[9] = '{19'h00042, {5'h00, 14'h0007}, 1'b0, 3, 2, 1, 19'h00043, 2};

        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
        zero_flag = 1'b0; pc_in = 19'h00055; imem_data = '0;
        @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_outs_zero", |{imem_addr, instr_out, instr_valid, update, branch, call, ret,
                                 jump, jump_address, pc_next, halted, stack_fault, bus_fault}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_no_req", imem_req, 0);
        run = 1'b1;

        for (int i = 0; i < 10; i++) begin
            zero_flag = vecs[i].zero;
            fetch($sformatf("v%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].ackw);
            collect(vecs[i].ew, code, ncyc, vcyc, lat, ja, pn, excl);
            check($sformatf("v%0d_code", i), code, vecs[i].code);
            check($sformatf("v%0d_ncyc", i), ncyc, 1);
            check($sformatf("v%0d_valid", i), vcyc, vecs[i].vcyc);
            check($sformatf("v%0d_lat", i), lat, vecs[i].vcyc);
            check($sformatf("v%0d_ja", i), ja, {5'b0, vecs[i].instr[13:0]});
            check($sformatf("v%0d_pn", i), pn, vecs[i].pn);
            check($sformatf("v%0d_excl", i), excl, 0);
        end

        // 16 CALLs fill the stack; the 17th must fault without a pulse.
        do_reset();
        run = 1'b1;
        ok = 0;
        for (int i = 0; i < 16; i++) begin
            fetch("call", 19'(i + 100), {5'h13, 14'h0200}, 0);
            collect(1, code, ncyc, vcyc, lat, ja, pn, excl);
            if (code == 3 && ncyc == 1 && excl == 0) ok++;
        end
        check("call16_pulses", ok, 16);
        fetch("call17", 19'h00200, {5'h13, 14'h0300}, 0);
        collect(1, code, ncyc, vcyc, lat, ja, pn, excl);
        check("call17_no_strobe", ncyc, 0);
        check("call17_fault", stack_fault, 1);
        check("call17_no_req", imem_req, 0);
        check("call17_not_halted", halted, 0);

        do_reset();
        run = 1'b1;
        fetch("ret0", 19'h00300, {5'h14, 14'h0000}, 1);
        collect(1, code, ncyc, vcyc, lat, ja, pn, excl);
        check("ret0_no_strobe", ncyc, 0);
        check("ret0_fault", stack_fault, 1);

        do_reset();
        check("rst_clears_fault", stack_fault, 0);
        run = 1'b1;
        fetch("halt", 19'h00400, {5'h1F, 14'h0000}, 0);
        collect(1, code, ncyc, vcyc, lat, ja, pn, excl);
        check("halt_no_strobe", ncyc, 0);
        nreq = 0;
        run = 1'b0;
        repeat (4) begin @(negedge clk); nreq += int'(imem_req); end
        run = 1'b1;
        repeat (6) begin @(negedge clk); nreq += int'(imem_req); end
        check("halt_no_req", nreq, 0);
        check("halt_sticky", halted, 1);
        check("halt_no_sfault", stack_fault, 0);

        // Asynchronous reset in the middle of a fetch.
        do_reset();
        run = 1'b1;
        pc_in = 19'h00555;
        @(negedge clk);
        check("midfetch_req", imem_req, 1);
        #2 reset = 1'b1;
        #1;
        check("async_req_drop", imem_req, 0);
        check("async_outs_zero", |{imem_addr, instr_out, instr_valid, update, branch, call, ret,
                                   jump, jump_address, pc_next, halted, stack_fault, bus_fault},
              0);
        @(negedge clk);
        reset = 1'b0;

        // No ack at all: watchdog fires four cycles after the request, or waits forever.
        @(negedge clk);
        check("tmo_req_rise", imem_req, 1);
`ifdef FETCH_TIMEOUT_EN
        repeat (3) @(negedge clk);
        check("tmo_req_before", {imem_req, bus_fault}, 2'b10);
        @(negedge clk);
        check("tmo_req_drop", imem_req, 0);
        check("tmo_bus_fault", bus_fault, 1);
        repeat (3) @(negedge clk);
        check("tmo_terminal", {imem_req, bus_fault}, 2'b01);
`else
        nreq = 0;
        repeat (20) begin @(negedge clk); nreq += int'(imem_req); end
        check("notmo_req_held", nreq, 20);
        check("notmo_bus_fault", bus_fault, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
